alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
- Downstream consumer of the keypad code checker: takes its 2-bit result code (OK=0, ERROR=2, NOKEY=3) and its entry strobe, and runs the home-alarm arming state machine.
- Drives siren, armed indicator and delay beeper from a door/PIR sensor input.
- Fully synchronous to one clock. Code-checker signals and the sensor are asynchronous to it and are synchronized internally.

Parameters:
- EXIT_CYCLES, 30000, cycles spent in EXIT delay before ARMED (>=1).
- ENTRY_CYCLES, 20000, cycles spent in ENTRY delay before ALARM (>=1).
- SIREN_CYCLES, 120000, cycles siren sounds before automatic re-arm (>=1).
- MAX_ERRORS, 3, consecutive ERROR codes that force ALARM (1..3).
- BEEP_BIT, 9, timer bit driving beep during EXIT/ENTRY.
- TIMER_W, 24, delay timer width; must hold the largest *_CYCLES-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- code_pulse  in  1  keypad digit strobe (same line that clocks the code checker), async
- code_result  in  2  code checker result: 0=OK, 2=ERROR, 3=NOKEY, 1 treated as NOKEY; async
- sensor  in  1  intrusion sensor, 1=tripped, async, level
- state  out  3  0=DISARMED 1=EXIT 2=ARMED 3=ENTRY 4=ALARM
- armed  out  1  high in ARMED and ENTRY
- siren  out  1  high in ALARM
- beep  out  1  timer[BEEP_BIT] while in EXIT or ENTRY, else 0
- fail_count  out  2  consecutive ERROR count, saturating at MAX_ERRORS

Behaviour:
Reset and clocking:
- One clock, clk. Reset rst_n is asynchronous assert, active-low; deassertion takes effect on the next clk edge.
- Reset values: state=DISARMED, armed=0, siren=0, beep=0, fail_count=0, timer=0, all sync flops 0.
- Reset mid-operation, including during ALARM, returns to DISARMED immediately with siren=0.
- All outputs are registered.

Input synchronization and events:
- code_pulse, code_result (both bits) and sensor each pass through a 2-FF synchronizer.
- Edge detection: pulse_rise = sync_pulse & ~sync_pulse_d.
- The code is sampled in the cycle after pulse_rise, giving the checker result time to settle. That cycle produces one event: ok_evt if the code is 0, err_evt if the code is 2, no event otherwise.
- Latency from code_pulse rising to the state change is 4 clk cycles, +/-1 for synchronizer phase.
- Held or repeated codes generate no event without a new pulse edge.

State machine:
- Timer semantics: on entry to a timed state the timer loads N-1 and decrements each cycle. The state is left in the cycle timer==0, so exactly N cycles are spent in it.
- DISARMED: ok_evt -> EXIT (load EXIT_CYCLES). Sensor ignored.
- EXIT: ok_evt -> DISARMED; timer==0 -> ARMED. Sensor ignored.
- ARMED: ok_evt -> DISARMED; sync sensor==1 -> ENTRY (load ENTRY_CYCLES).
- ENTRY: ok_evt -> DISARMED; timer==0 -> ALARM (load SIREN_CYCLES). Sensor ignored.
- ALARM: ok_evt -> DISARMED; timer==0 -> ARMED. If sensor is still high, ENTRY follows on the next cycle.

Error counter:
- err_evt increments fail_count, saturating at MAX_ERRORS.
- If the increment reaches MAX_ERRORS in any state other than ALARM, the next state is ALARM (load SIREN_CYCLES), overriding other transitions.
- err_evt in ALARM increments the counter (saturating) but does not reload the timer.
- ok_evt clears fail_count. Any entry to DISARMED also clears it.

Priority within a cycle (highest first): reset > ok_evt > error-threshold > timer expiry > sensor.
- ok_evt and err_evt cannot coincide.

Test Plan:
Bench parameters for all scenarios: EXIT=8, ENTRY=6, SIREN=10, MAX_ERRORS=3, BEEP_BIT=1.
- Arm: code_pulse with result 0 from DISARMED -> state=1 within 4+/-1 cycles; exactly 8 cycles later state=2, armed=1; beep toggles every 2 cycles during EXIT.
- Intrusion: in ARMED raise sensor -> state=3 after sync; no code entered -> after 6 cycles state=4, siren=1; 10 cycles later state=2, siren=0 (sensor low).
- Disarm in ENTRY: sensor trip, then OK code at ENTRY cycle 3 -> state=0, armed=0, siren never asserted; OK event coinciding with timer==0 -> DISARMED, not ALARM.
- Error threshold: in ARMED send results 2,2 -> fail_count=2, state=2; third 2 -> state=4, fail_count=3; then 0 -> state=0, fail_count=0.
- NOKEY and held codes: pulses with result 3 or 1 -> no state or counter change; result 0 held with no new pulse edge -> exactly one event.
- Async reset: assert rst_n=0 mid-ALARM -> siren=0, state=0, fail_count=0 immediately, without waiting for a clk edge; release -> stays DISARMED.

Source files
------------

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - home-alarm arming state machine driven by keypad code results and an intrusion sensor
module alarm_controller #(
  parameter int EXIT_CYCLES  = 30000,
  parameter int ENTRY_CYCLES = 20000,
  parameter int SIREN_CYCLES = 120000,
  parameter int MAX_ERRORS   = 3,
  parameter int BEEP_BIT     = 9,
  parameter int TIMER_W      = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_pulse,
  input  logic [1:0] code_result,
  input  logic       sensor,
  output logic [2:0] state,
  output logic       armed,
  output logic       siren,
  output logic       beep,
  output logic [1:0] fail_count
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  localparam logic [TIMER_W-1:0] T_ONE      = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] EXIT_LOAD  = TIMER_W'(EXIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ENTRY_LOAD = TIMER_W'(ENTRY_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SIREN_LOAD = TIMER_W'(SIREN_CYCLES - 1);
  localparam logic [1:0]         MAX_FAIL   = 2'(MAX_ERRORS);

  state_t               cur_state, nxt_state;
  logic [TIMER_W-1:0]   timer, nxt_timer;
  logic [1:0]           nxt_fail, fail_inc;
  logic [3:0]           meta, sync;
  logic                 pulse_d, sample_en;
  logic                 sync_pulse, sync_sensor;
  logic [1:0]           sync_code;
  logic                 pulse_rise, ok_evt, err_evt;

  // Bit order: {sensor, code_result[1:0], code_pulse}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta      <= '0;
      sync      <= '0;
      pulse_d   <= 1'b0;
      sample_en <= 1'b0;
    end else begin
      meta      <= {sensor, code_result, code_pulse};
      sync      <= meta;
      pulse_d   <= sync_pulse;
      sample_en <= pulse_rise;
    end
  end

  assign sync_pulse  = sync[0];
  assign sync_code   = sync[2:1];
  assign sync_sensor = sync[3];
  assign pulse_rise  = sync_pulse & ~pulse_d;

  // The code is read one cycle after the strobe edge so the checker result has settled.
  assign ok_evt  = sample_en & (sync_code == 2'd0);
  assign err_evt = sample_en & (sync_code == 2'd2);

  assign fail_inc = (fail_count >= MAX_FAIL) ? MAX_FAIL : fail_count + 2'd1;

  always_comb begin
    nxt_state = cur_state;
    nxt_timer = (timer != '0) ? timer - T_ONE : '0;
    nxt_fail  = err_evt ? fail_inc : fail_count;
    if (ok_evt) begin
      nxt_fail = '0;
      if (cur_state == S_DISARMED) begin
        nxt_state = S_EXIT;
        nxt_timer = EXIT_LOAD;
      end else begin
        nxt_state = S_DISARMED;
        nxt_timer = '0;
      end
    end else if (err_evt && (fail_inc == MAX_FAIL) && (cur_state != S_ALARM)) begin
      nxt_state = S_ALARM;
      nxt_timer = SIREN_LOAD;
    end else begin
      case (cur_state)
        S_EXIT: begin
          if (timer == '0) nxt_state = S_ARMED;
        end
        S_ARMED: begin
          if (sync_sensor) begin
            nxt_state = S_ENTRY;
            nxt_timer = ENTRY_LOAD;
          end
        end
        S_ENTRY: begin
          if (timer == '0) begin
            nxt_state = S_ALARM;
            nxt_timer = SIREN_LOAD;
          end
        end
        S_ALARM: begin
          if (timer == '0) nxt_state = S_ARMED;
        end
        default: ;
      endcase
    end
  end

  // Indicator flops are fed from next-state values so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state  <= S_DISARMED;
      timer      <= '0;
      fail_count <= '0;
      armed      <= 1'b0;
      siren      <= 1'b0;
      beep       <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      timer      <= nxt_timer;
      fail_count <= nxt_fail;
      armed      <= (nxt_state == S_ARMED) || (nxt_state == S_ENTRY);
      siren      <= (nxt_state == S_ALARM);
      beep       <= ((nxt_state == S_EXIT) || (nxt_state == S_ENTRY)) ? nxt_timer[BEEP_BIT] : 1'b0;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - directed self-checking bench for alarm_controller
module tb_alarm_controller;

  logic       clk;
  logic       rst_n;
  logic       code_pulse;
  logic [1:0] code_result;
  logic       sensor;
  logic [2:0] state;
  logic       armed;
  logic       siren;
  logic       beep;
  logic [1:0] fail_count;

  int n_cmp;
  int n_fail;

  alarm_controller #(
    .EXIT_CYCLES (8),
    .ENTRY_CYCLES(6),
    .SIREN_CYCLES(10),
    .MAX_ERRORS  (3),
    .BEEP_BIT    (1),
    .TIMER_W     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_pulse (code_pulse),
    .code_result(code_result),
    .sensor     (sensor),
    .state      (state),
    .armed      (armed),
    .siren      (siren),
    .beep       (beep),
    .fail_count (fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int OP_WAIT   = 0;
  localparam int OP_PULSE  = 1;
  localparam int OP_SENSOR = 2;

  typedef struct {
    int         op;
    logic [1:0] arg;
    int         cycles;
    logic [2:0] st;
    logic       arm;
    logic       sir;
    logic [1:0] fc;
  } step_t;

  step_t steps [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pulse(input logic [1:0] r);
    code_result = r;
    code_pulse  = 1'b1;
    tick(1);
    code_pulse  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    logic exp_beep [8];
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    code_pulse = 1'b0;
    code_result = 2'd3;
    sensor = 1'b0;

    steps[0]  = '{OP_WAIT,   2'd0, 2, 3'd0, 1'b0, 1'b0, 2'd0};
    steps[1]  = '{OP_PULSE,  2'd0, 5, 3'd1, 1'b0, 1'b0, 2'd0};
    steps[2]  = '{OP_WAIT,   2'd0, 6, 3'd1, 1'b0, 1'b0, 2'd0};
    steps[3]  = '{OP_WAIT,   2'd0, 1, 3'd2, 1'b1, 1'b0, 2'd0};
    steps[4]  = '{OP_SENSOR, 2'd1, 3, 3'd3, 1'b1, 1'b0, 2'd0};
    steps[5]  = '{OP_SENSOR, 2'd0, 5, 3'd3, 1'b1, 1'b0, 2'd0};
    steps[6]  = '{OP_WAIT,   2'd0, 1, 3'd4, 1'b0, 1'b1, 2'd0};
    steps[7]  = '{OP_WAIT,   2'd0, 9, 3'd4, 1'b0, 1'b1, 2'd0};
    steps[8]  = '{OP_WAIT,   2'd0, 1, 3'd2, 1'b1, 1'b0, 2'd0};
    steps[9]  = '{OP_PULSE,  2'd2, 6, 3'd2, 1'b1, 1'b0, 2'd1};
    steps[10] = '{OP_PULSE,  2'd2, 6, 3'd2, 1'b1, 1'b0, 2'd2};
    steps[11] = '{OP_PULSE,  2'd2, 4, 3'd4, 1'b0, 1'b1, 2'd3};
    steps[12] = '{OP_PULSE,  2'd0, 6, 3'd0, 1'b0, 1'b0, 2'd0};
    steps[13] = '{OP_PULSE,  2'd2, 6, 3'd0, 1'b0, 1'b0, 2'd1};
    steps[14] = '{OP_PULSE,  2'd3, 6, 3'd0, 1'b0, 1'b0, 2'd1};
    steps[15] = '{OP_PULSE,  2'd1, 6, 3'd0, 1'b0, 1'b0, 2'd1};
    steps[16] = '{OP_PULSE,  2'd0, 5, 3'd1, 1'b0, 1'b0, 2'd0};

    exp_beep[0] = 1'b1; exp_beep[1] = 1'b1; exp_beep[2] = 1'b0; exp_beep[3] = 1'b0;
    exp_beep[4] = 1'b1; exp_beep[5] = 1'b1; exp_beep[6] = 1'b0; exp_beep[7] = 1'b0;

    tick(1);
    check("reset_state", 32'(state), 0);
    check("reset_siren", 32'(siren), 0);
    check("reset_beep", 32'(beep), 0);
    rst_n = 1'b1;
    tick(1);

    for (int i = 0; i < 17; i++) begin
      case (steps[i].op)
        OP_PULSE: begin
          send_pulse(steps[i].arg);
          tick(steps[i].cycles - 1);
        end
        OP_SENSOR: begin
          sensor = steps[i].arg[0];
          tick(steps[i].cycles);
        end
        default: tick(steps[i].cycles);
      endcase
      check($sformatf("step%0d_state", i), 32'(state), 32'(steps[i].st));
      check($sformatf("step%0d_armed", i), 32'(armed), 32'(steps[i].arm));
      check($sformatf("step%0d_siren", i), 32'(siren), 32'(steps[i].sir));
      check($sformatf("step%0d_fail", i), 32'(fail_count), 32'(steps[i].fc));
    end

    // Beep pattern through the whole exit delay
    do_reset();
    send_pulse(2'd0);
    tick(3);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("exit_beep%0d", i), 32'(beep), 32'(exp_beep[i]));
      check($sformatf("exit_state%0d", i), 32'(state), 1);
      tick(1);
    end
    check("armed_state", 32'(state), 2);
    check("armed_beep", 32'(beep), 0);

    // Held OK code: one event only
    do_reset();
    code_result = 2'd0;
    code_pulse  = 1'b1;
    tick(6);
    check("held_exit", 32'(state), 1);
    tick(8);
    check("held_armed", 32'(state), 2);
    code_pulse = 1'b0;
    tick(3);
    check("held_still_armed", 32'(state), 2);

    // Disarm mid-ENTRY; siren must stay off
    sensor = 1'b1;
    tick(3);
    check("entry_reached", 32'(state), 3);
    sensor = 1'b0;
    send_pulse(2'd0);
    check("entry_siren0", 32'(siren), 0);
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      check($sformatf("entry_siren%0d", i), 32'(siren), 0);
    end
    check("entry_disarm_state", 32'(state), 0);
    check("entry_disarm_armed", 32'(armed), 0);

    // OK event in the same cycle the entry timer hits zero
    send_pulse(2'd0);
    tick(11);
    check("rearm_state", 32'(state), 2);
    sensor = 1'b1;
    tick(3);
    sensor = 1'b0;
    tick(2);
    send_pulse(2'd0);
    tick(2);
    check("coincide_pre", 32'(state), 3);
    tick(1);
    check("coincide_state", 32'(state), 0);
    check("coincide_siren", 32'(siren), 0);

    // Asynchronous reset during ALARM
    for (int i = 0; i < 3; i++) begin
      send_pulse(2'd2);
      tick(5);
    end
    check("pre_reset_state", 32'(state), 4);
    check("pre_reset_siren", 32'(siren), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_state", 32'(state), 0);
    check("async_siren", 32'(siren), 0);
    check("async_fail", 32'(fail_count), 0);
    check("async_armed", 32'(armed), 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("post_reset_state", 32'(state), 0);
    check("post_reset_siren", 32'(siren), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
